// File: rtl/mem_access_unit.sv
// MEM-stage load/store front end: validates, encodes and issues one access to the data cache.
// Optional build macro MAU_PERF_CNT_EN adds saturating hit/miss/stall performance counters.
module mem_access_unit #(
    parameter int TIMEOUT_CYC = 16,
    parameter int ADDR_W      = 12
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              MEM_REQ,
    input  logic              MEM_WE,
    input  logic [2:0]        MEM_FUNCT3,
    input  logic [31:0]       MEM_ADDR,
    input  logic [31:0]       MEM_WDATA,
    output logic [31:0]       MEM_RDATA,
    output logic              MEM_DONE,
    output logic [1:0]        MEM_ERR,
    output logic              STALL,
    output logic              Cache_CSN,
    output logic              Cache_WEN,
    output logic [ADDR_W-1:0] Cache_ADDR,
    output logic [3:0]        Cache_BE,
    output logic [31:0]       Cache_DI,
    input  logic [31:0]       Cache_DOUT,
    input  logic              RDY,
    input  logic              VALID,
`ifdef MAU_PERF_CNT_EN
    output logic [31:0]       PERF_HIT,
    output logic [31:0]       PERF_MISS,
    output logic [31:0]       PERF_STALL,
`endif
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        f3_q;
    logic [1:0]        lane_q;
    logic              we_q;
    logic              wen_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       di_q;
    logic [31:0]       rdata_q;
    logic [1:0]        err_q;

    logic              f3_bad, misal;
    logic [1:0]        req_err;
    logic [3:0]        be_d;
    logic [31:0]       di_d;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       load_data;
    logic              cache_hit, timeout;

    // Only the word-address bits reach the cache; the upper address bits are dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^MEM_ADDR[31:ADDR_W+2];

    // Request decode: funct3 legality takes precedence over alignment.
    always_comb begin
        f3_bad  = MEM_WE ? (MEM_FUNCT3[2] || (MEM_FUNCT3[1:0] == 2'b11))
                         : ((MEM_FUNCT3[1:0] == 2'b11) || (MEM_FUNCT3[2:1] == 2'b11));
        misal   = ((MEM_FUNCT3[1:0] == 2'b01) && MEM_ADDR[0]) ||
                  ((MEM_FUNCT3[1:0] == 2'b10) && (MEM_ADDR[1:0] != 2'b00));
        req_err = f3_bad ? 2'b10 : (misal ? 2'b01 : 2'b00);
        case (MEM_FUNCT3[1:0])
            2'b00: begin
                be_d = 4'b0001 << MEM_ADDR[1:0];
                di_d = {4{MEM_WDATA[7:0]}};
            end
            2'b01: begin
                be_d = MEM_ADDR[1] ? 4'b1100 : 4'b0011;
                di_d = {2{MEM_WDATA[15:0]}};
            end
            default: begin
                be_d = 4'b1111;
                di_d = MEM_WDATA;
            end
        endcase
        if (!MEM_WE) begin
            be_d = 4'b1111;
            di_d = 32'h0;
        end
    end

    // Load extraction from the lane chosen by the registered byte offset.
    always_comb begin
        ld_byte = Cache_DOUT[8*lane_q +: 8];
        ld_half = lane_q[1] ? Cache_DOUT[31:16] : Cache_DOUT[15:0];
        case (f3_q[1:0])
            2'b00:   load_data = {{24{~f3_q[2] & ld_byte[7]}}, ld_byte};
            2'b01:   load_data = {{16{~f3_q[2] & ld_half[15]}}, ld_half};
            default: load_data = Cache_DOUT;
        endcase
        if (we_q) load_data = 32'h0;
    end

    // Cache handshake: CSN is low for the whole of ISSUE/WAIT with every cache
    // output held; the access completes at the first posedge with RDY && VALID.
    assign cache_hit = RDY && VALID;
    assign timeout   = (cnt_q == CNT_MAX);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        STALL     = 1'b0;
        Cache_CSN = 1'b1;
        MEM_DONE  = 1'b0;
        case (state_q)
            IDLE: begin
                STALL = MEM_REQ;
                if (MEM_REQ) state_d = (req_err != 2'b00) ? RESP : ISSUE;
            end
            ISSUE: begin
                STALL     = 1'b1;
                Cache_CSN = 1'b0;
                state_d   = cache_hit ? RESP : WAIT;
            end
            WAIT: begin
                STALL     = 1'b1;
                Cache_CSN = 1'b0;
                if (cache_hit || timeout) state_d = RESP;
            end
            RESP: begin
                MEM_DONE = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt_q   <= '0;
            f3_q    <= 3'b0;
            lane_q  <= 2'b0;
            we_q    <= 1'b0;
            wen_q   <= 1'b1;
            addr_q  <= '0;
            be_q    <= 4'b0;
            di_q    <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (MEM_REQ) begin
                        err_q   <= req_err;
                        rdata_q <= 32'h0;
                        if (req_err == 2'b00) begin
                            f3_q   <= MEM_FUNCT3;
                            lane_q <= MEM_ADDR[1:0];
                            we_q   <= MEM_WE;
                            wen_q  <= ~MEM_WE;
                            addr_q <= MEM_ADDR[ADDR_W+1:2];
                            be_q   <= be_d;
                            di_q   <= di_d;
                        end
                    end
                end
                ISSUE: begin
                    cnt_q <= '0;
                    if (cache_hit) rdata_q <= load_data;
                end
                WAIT: begin
                    if (cache_hit) begin
                        rdata_q <= load_data;
                    end else if (timeout) begin
                        err_q   <= 2'b11;
                        rdata_q <= 32'h0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: cnt_q <= '0;
                default: cnt_q <= '0;
            endcase
        end
    end

`ifdef MAU_PERF_CNT_EN
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            PERF_HIT   <= 32'h0;
            PERF_MISS  <= 32'h0;
            PERF_STALL <= 32'h0;
        end else begin
            if (state_q == ISSUE && state_d == RESP && PERF_HIT != 32'hFFFF_FFFF)
                PERF_HIT <= PERF_HIT + 32'd1;
            if (state_q == ISSUE && state_d == WAIT && PERF_MISS != 32'hFFFF_FFFF)
                PERF_MISS <= PERF_MISS + 32'd1;
            if (STALL && PERF_STALL != 32'hFFFF_FFFF)
                PERF_STALL <= PERF_STALL + 32'd1;
        end
    end
`endif

    assign MEM_RDATA  = rdata_q;
    assign MEM_ERR    = err_q;
    assign Cache_WEN  = wen_q;
    assign Cache_ADDR = addr_q;
    assign Cache_BE   = be_q;
    assign Cache_DI   = di_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: hit, byte/half extraction, store encoding, miss, errors, timeout, reset abort.
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        MEM_REQ, MEM_WE;
    logic [2:0]  MEM_FUNCT3;
    logic [31:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
    logic        MEM_DONE, STALL;
    logic [1:0]  MEM_ERR;
    logic        Cache_CSN, Cache_WEN;
    logic [11:0] Cache_ADDR;
    logic [3:0]  Cache_BE;
    logic [31:0] Cache_DI, Cache_DOUT;
    logic        RDY, VALID;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    mem_access_unit #(.TIMEOUT_CYC(16), .ADDR_W(12)) dut (
        .CLK(CLK), .RSTn(RSTn), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
        .MEM_FUNCT3(MEM_FUNCT3), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA(MEM_RDATA), .MEM_DONE(MEM_DONE), .MEM_ERR(MEM_ERR), .STALL(STALL),
        .Cache_CSN(Cache_CSN), .Cache_WEN(Cache_WEN), .Cache_ADDR(Cache_ADDR),
        .Cache_BE(Cache_BE), .Cache_DI(Cache_DI), .Cache_DOUT(Cache_DOUT),
        .RDY(RDY), .VALID(VALID), .dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Single-cycle hit: request at a negedge in IDLE, cache answers during ISSUE.
    task automatic run_hit(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] dout, input logic [31:0] exp_caddr,
                           input logic [31:0] exp_be, input logic [31:0] exp_di,
                           input logic [31:0] exp_wen, input logic [31:0] exp_rdata);
        MEM_REQ = 1'b1; MEM_WE = we; MEM_FUNCT3 = f3; MEM_ADDR = addr; MEM_WDATA = wdata;
        RDY = 1'b1; VALID = 1'b1; Cache_DOUT = dout;
        #1;
        check({tag, ".stall_idle"}, {31'b0, STALL}, 32'd1);
        @(negedge CLK);
        check({tag, ".csn"}, {31'b0, Cache_CSN}, 32'd0);
        check({tag, ".caddr"}, {20'b0, Cache_ADDR}, exp_caddr);
        check({tag, ".be"}, {28'b0, Cache_BE}, exp_be);
        check({tag, ".di"}, Cache_DI, exp_di);
        check({tag, ".wen"}, {31'b0, Cache_WEN}, exp_wen);
        check({tag, ".stall_issue"}, {31'b0, STALL}, 32'd1);
        check({tag, ".done_early"}, {31'b0, MEM_DONE}, 32'd0);
        @(negedge CLK);
        check({tag, ".done"}, {31'b0, MEM_DONE}, 32'd1);
        check({tag, ".rdata"}, MEM_RDATA, exp_rdata);
        check({tag, ".err"}, {30'b0, MEM_ERR}, 32'd0);
        check({tag, ".stall_resp"}, {31'b0, STALL}, 32'd0);
        check({tag, ".csn_resp"}, {31'b0, Cache_CSN}, 32'd1);
        MEM_REQ = 1'b0; RDY = 1'b0; VALID = 1'b0;
        @(negedge CLK);
        check({tag, ".done_once"}, {31'b0, MEM_DONE}, 32'd0);
    endtask

    task automatic run_err(input string tag, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] exp_err);
        MEM_REQ = 1'b1; MEM_WE = 1'b0; MEM_FUNCT3 = f3; MEM_ADDR = addr;
        #1;
        check({tag, ".stall"}, {31'b0, STALL}, 32'd1);
        check({tag, ".csn_idle"}, {31'b0, Cache_CSN}, 32'd1);
        @(negedge CLK);
        check({tag, ".done"}, {31'b0, MEM_DONE}, 32'd1);
        check({tag, ".err"}, {30'b0, MEM_ERR}, exp_err);
        check({tag, ".csn_resp"}, {31'b0, Cache_CSN}, 32'd1);
        check({tag, ".rdata"}, MEM_RDATA, 32'd0);
        MEM_REQ = 1'b0;
        @(negedge CLK);
        check({tag, ".done_once"}, {31'b0, MEM_DONE}, 32'd0);
    endtask

    initial begin
        int  cyc;
        bit  done_seen;
        bit  csn_hi;

        RSTn = 1'b0; MEM_REQ = 1'b0; MEM_WE = 1'b0; MEM_FUNCT3 = 3'b0;
        MEM_ADDR = 32'h0; MEM_WDATA = 32'h0; Cache_DOUT = 32'h0; RDY = 1'b0; VALID = 1'b0;

        // Reset values
        @(negedge CLK);
        check("rst.csn", {31'b0, Cache_CSN}, 32'd1);
        check("rst.wen", {31'b0, Cache_WEN}, 32'd1);
        check("rst.caddr", {20'b0, Cache_ADDR}, 32'd0);
        check("rst.be", {28'b0, Cache_BE}, 32'd0);
        check("rst.di", Cache_DI, 32'd0);
        check("rst.rdata", MEM_RDATA, 32'd0);
        check("rst.done", {31'b0, MEM_DONE}, 32'd0);
        check("rst.err", {30'b0, MEM_ERR}, 32'd0);
        check("rst.stall", {31'b0, STALL}, 32'd0);
        check("rst.state", {30'b0, dbg_state}, 32'd0);
        RSTn = 1'b1;
        @(negedge CLK);

        // Hits: LW, LB/LBU on lane 3, SH on upper half
        run_hit("lw_hit", 1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF,
                32'h010, 32'hF, 32'h0, 32'd1, 32'hDEAD_BEEF);
        run_hit("lb", 1'b0, 3'b000, 32'h0000_0043, 32'h0, 32'h80FF_0000,
                32'h010, 32'hF, 32'h0, 32'd1, 32'hFFFF_FF80);
        run_hit("lbu", 1'b0, 3'b100, 32'h0000_0043, 32'h0, 32'h80FF_0000,
                32'h010, 32'hF, 32'h0, 32'd1, 32'h0000_0080);
        run_hit("lh_hi", 1'b0, 3'b001, 32'h0000_0082, 32'h0, 32'h9234_0000,
                32'h020, 32'hF, 32'h0, 32'd1, 32'hFFFF_9234);
        run_hit("lhu_lo", 1'b0, 3'b101, 32'h0000_0080, 32'h0, 32'h0000_8001,
                32'h020, 32'hF, 32'h0, 32'd1, 32'h0000_8001);
        run_hit("sh", 1'b1, 3'b001, 32'h0000_0006, 32'h1234_ABCD, 32'h5555_5555,
                32'h001, 32'hC, 32'hABCD_ABCD, 32'd0, 32'h0);
        run_hit("sb", 1'b1, 3'b000, 32'h0000_0009, 32'h0000_00A5, 32'h0,
                32'h002, 32'h2, 32'hA5A5_A5A5, 32'd0, 32'h0);
        run_hit("sw", 1'b1, 3'b010, 32'h0000_3FFC, 32'hCAFE_F00D, 32'h0,
                32'hFFF, 32'hF, 32'hCAFE_F00D, 32'd0, 32'h0);

        // Miss: RDY low for 5 cycles, then the cache answers
        MEM_REQ = 1'b1; MEM_WE = 1'b0; MEM_FUNCT3 = 3'b010; MEM_ADDR = 32'h0000_0100;
        RDY = 1'b0; VALID = 1'b0; Cache_DOUT = 32'h0000_0007;
        csn_hi = 1'b0; done_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (Cache_CSN) csn_hi = 1'b1;
            if (MEM_DONE) done_seen = 1'b1;
        end
        check("miss.csn_low", {31'b0, csn_hi}, 32'd0);
        check("miss.no_early_done", {31'b0, done_seen}, 32'd0);
        check("miss.state_wait", {30'b0, dbg_state}, 32'd2);
        RDY = 1'b1; VALID = 1'b1;
        @(negedge CLK);
        check("miss.done", {31'b0, MEM_DONE}, 32'd1);
        check("miss.rdata", MEM_RDATA, 32'd7);
        check("miss.err", {30'b0, MEM_ERR}, 32'd0);
        MEM_REQ = 1'b0; RDY = 1'b0; VALID = 1'b0;
        @(negedge CLK);
        check("miss.done_once", {31'b0, MEM_DONE}, 32'd0);

        // Error paths never select the cache
        run_err("misal_lw", 3'b010, 32'h0000_0002, 32'd1);
        run_err("misal_lh", 3'b001, 32'h0000_0001, 32'd1);
        run_err("bad_f3", 3'b011, 32'h0000_0000, 32'd2);

        // Timeout: ISSUE + 16 WAIT cycles, DONE on the 18th cycle after the request
        MEM_REQ = 1'b1; MEM_WE = 1'b0; MEM_FUNCT3 = 3'b010; MEM_ADDR = 32'h0000_0200;
        RDY = 1'b0; VALID = 1'b1; Cache_DOUT = 32'h1111_1111;
        cyc = 0; done_seen = 1'b0; csn_hi = 1'b0;
        while (!done_seen && cyc < 40) begin
            @(negedge CLK);
            cyc++;
            if (MEM_DONE) done_seen = 1'b1;
            else if (Cache_CSN) csn_hi = 1'b1;
        end
        check("tmo.done_seen", {31'b0, done_seen}, 32'd1);
        check("tmo.latency", cyc, 32'd18);
        check("tmo.csn_low", {31'b0, csn_hi}, 32'd0);
        check("tmo.err", {30'b0, MEM_ERR}, 32'd3);
        check("tmo.rdata", MEM_RDATA, 32'd0);
        MEM_REQ = 1'b0; VALID = 1'b0;
        @(negedge CLK);

        // Reset mid-WAIT abandons the access
        MEM_REQ = 1'b1; MEM_FUNCT3 = 3'b010; MEM_ADDR = 32'h0000_0300; RDY = 1'b0;
        repeat (4) @(negedge CLK);
        check("rstw.csn_before", {31'b0, Cache_CSN}, 32'd0);
        RSTn = 1'b0;
        #1;
        check("rstw.csn", {31'b0, Cache_CSN}, 32'd1);
        check("rstw.state", {30'b0, dbg_state}, 32'd0);
        check("rstw.done", {31'b0, MEM_DONE}, 32'd0);
        MEM_REQ = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;
        done_seen = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            if (MEM_DONE) done_seen = 1'b1;
        end
        check("rstw.no_done", {31'b0, done_seen}, 32'd0);
        check("rstw.idle", {30'b0, dbg_state}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store front end sitting directly upstream of the data cache.
- Takes one pipeline memory request (byte address, funct3, store data) and checks alignment and funct3.
- Builds the word address, byte enables and lane-replicated store data, then drives the cache chip-select handshake and waits on the cache's RDY/VALID.
- Returns a sign/zero-extended load result, stalls the pipeline until the access completes, and reports errors.

Parameters:
- TIMEOUT_CYC, 16: maximum cycles spent in WAIT before the access is aborted with a timeout error.
- ADDR_W, 12: cache word-address width; Cache_ADDR = MEM_ADDR[ADDR_W+1:2].

Ports:
- CLK  in  1  system clock; block logic on posedge.
- RSTn  in  1  asynchronous active-low reset.
- MEM_REQ  in  1  request valid; held by the pipeline while STALL=1.
- MEM_WE  in  1  1=store, 0=load.
- MEM_FUNCT3  in  3  RISC-V load/store funct3.
- MEM_ADDR  in  32  byte address.
- MEM_WDATA  in  32  store data, low-aligned.
- MEM_RDATA  out  32  extended load data, valid while MEM_DONE=1.
- MEM_DONE  out  1  one-cycle completion pulse.
- MEM_ERR  out  2  00 none, 01 misaligned, 10 illegal funct3, 11 timeout; valid with MEM_DONE.
- STALL  out  1  pipeline hold.
- Cache_CSN  out  1  cache chip select, active low.
- Cache_WEN  out  1  0=write, 1=read.
- Cache_ADDR  out  ADDR_W  word address.
- Cache_BE  out  4  byte enables.
- Cache_DI  out  32  store data to cache.
- Cache_DOUT  in  32  cache read data.
- RDY  in  1  cache ready.
- VALID  in  1  cache data valid.

Behaviour:
- Reset (async, RSTn=0):
  - State IDLE; Cache_CSN=1, Cache_WEN=1, Cache_ADDR=0, Cache_BE=0, Cache_DI=0.
  - MEM_RDATA=0, MEM_DONE=0, MEM_ERR=0, timeout counter=0.
  - Reset mid-access abandons the access immediately and CSN returns high asynchronously.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - MEM_REQ=0: stay in IDLE.
  - MEM_REQ=1, request legal: register cache outputs; next state ISSUE.
  - MEM_REQ=1, request illegal: register MEM_ERR (01 or 10); next state RESP; the cache is never selected.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code gives MEM_ERR=10.
- Misaligned (MEM_ERR=01): halfword with ADDR[0]=1, or word with ADDR[1:0]!=0.
- Store encoding:
  - SB: Cache_DI={4{WDATA[7:0]}}, BE=0001<<ADDR[1:0].
  - SH: Cache_DI={2{WDATA[15:0]}}, BE=0011 if ADDR[1]=0 else 1100.
  - SW: Cache_DI=WDATA, BE=1111.
  - Loads drive BE=1111 and Cache_WEN=1; stores drive Cache_WEN=0.
- ISSUE: Cache_CSN=0, all cache outputs held stable. The cache evaluates on the mid-cycle negedge.
  - RDY=1 and VALID=1 at the closing posedge: hit; capture the result; next state RESP.
  - Otherwise: next state WAIT.
  - VALID left over from a prior access is never sampled in IDLE.
- WAIT: Cache_CSN=0, outputs held, counter increments each cycle.
  - RDY=1 and VALID=1: capture; next state RESP.
  - Counter reaches TIMEOUT_CYC-1: MEM_ERR=11, MEM_RDATA=0; next state RESP.
- Load extraction from Cache_DOUT:
  - Byte lane = ADDR[1:0]; halfword lane = ADDR[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Stores return MEM_RDATA=0.
- RESP:
  - Cache_CSN=1; MEM_DONE=1 for exactly one cycle; MEM_RDATA and MEM_ERR valid.
  - Counter cleared; next state IDLE unconditionally. MEM_REQ is ignored in RESP, so there is no double issue.
- STALL (combinational) = (IDLE && MEM_REQ) || ISSUE || WAIT; STALL=0 in RESP.
- Latency, request seen to MEM_DONE:
  - Cache hit: 2 cycles.
  - Error: 1 cycle.
  - Miss: 2 + (WAIT cycles).
- Back-to-back requests: minimum issue spacing is 3 cycles (IDLE→ISSUE→RESP→IDLE).

Optional Feature:
- Macro MAU_PERF_CNT_EN.
- When defined, adds outputs PERF_HIT[31:0], PERF_MISS[31:0], PERF_STALL[31:0]:
  - PERF_HIT increments on ISSUE→RESP.
  - PERF_MISS increments on ISSUE→WAIT.
  - PERF_STALL increments every cycle STALL=1.
  - All are async-cleared by RSTn and saturate at 0xFFFFFFFF.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- LW at 0x0000_0040, cache returns RDY=1/VALID=1 in ISSUE with DOUT=0xDEADBEEF → Cache_ADDR=0x010, BE=1111, MEM_DONE in 3rd cycle, MEM_RDATA=0xDEADBEEF, ERR=00, STALL high exactly 2 cycles.
- LB at 0x0000_0043 with DOUT=0x80FF_0000 → MEM_RDATA=0xFFFF_FF80; LBU on the same stimulus → 0x0000_0080.
- SH at 0x0000_0006, WDATA=0x1234_ABCD → Cache_WEN=0, BE=1100, Cache_DI=0xABCD_ABCD, Cache_ADDR=0x001.
- LW miss: RDY=0 for 5 cycles, then RDY=1/VALID=1 with DOUT=0x00000007 → CSN held low throughout, MEM_DONE once, RDATA=7.
- LW at 0x0000_0002 → CSN never low, MEM_DONE next cycle, ERR=01; funct3=011 → ERR=10.
- RDY stuck 0 → ERR=11 after TIMEOUT_CYC WAIT cycles; second run with RSTn pulsed low mid-WAIT → CSN=1 immediately, state IDLE, no MEM_DONE.
